// File: rtl/fft_pkg.sv
// Shared types and width helpers for the streaming radix-2 FFT blocks.
// Holds the default sample width, output width derivation, sample struct and FSM states.
package fft_pkg;

    localparam int DW_DEF = 8;

    // Two butterfly stages each add one bit of growth.
    function automatic int ow_of(input int dw);
        return dw + 2;
    endfunction

    typedef struct packed {
        logic signed [DW_DEF-1:0] re;
        logic signed [DW_DEF-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        BF1     = 2'd1,
        BF2     = 2'd2,
        EMIT    = 2'd3
    } state_t;

endpackage

// File: rtl/bfly2_fwd.sv
// Combinational complex radix-2 butterfly: sum and difference with one bit of growth.
module bfly2_fwd #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a_re,
    input  logic [W-1:0] i_a_im,
    input  logic [W-1:0] i_b_re,
    input  logic [W-1:0] i_b_im,
    output logic [W:0]   o_sum_re,
    output logic [W:0]   o_sum_im,
    output logic [W:0]   o_dif_re,
    output logic [W:0]   o_dif_im
);

    logic [W:0] w_a_re;
    logic [W:0] w_a_im;
    logic [W:0] w_b_re;
    logic [W:0] w_b_im;

    // Sign-extend before adding so the extra bit carries the true result.
    assign w_a_re = {i_a_re[W-1], i_a_re};
    assign w_a_im = {i_a_im[W-1], i_a_im};
    assign w_b_re = {i_b_re[W-1], i_b_re};
    assign w_b_im = {i_b_im[W-1], i_b_im};

    assign o_sum_re = w_a_re + w_b_re;
    assign o_sum_im = w_a_im + w_b_im;
    assign o_dif_re = w_a_re - w_b_re;
    assign o_dif_im = w_a_im - w_b_im;

endmodule

// File: rtl/fft4_fwd_stream.sv
// Streaming 4-point forward DFT: collect 4 samples, two butterfly stages,
// then emit the four unscaled bins in natural order.
module fft4_fwd_stream
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int OW = ow_of(DW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_re,
    output logic [OW-1:0] out_im,
    output logic [1:0]    out_idx,
    output logic          out_last,
    output state_t        dbg_state
);

    localparam int AW = DW + 1;
    localparam int BW = DW + 2;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_cnt;
    logic [1:0]    r_idx;
    logic [DW-1:0] r_x_re [4];
    logic [DW-1:0] r_x_im [4];
    logic [AW-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
    logic [AW-1:0] r_c_re, r_c_im, r_d_re, r_d_im;
    logic [BW-1:0] r_bin_re [4];
    logic [BW-1:0] r_bin_im [4];

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_in_fire;
    logic          w_out_fire;
    logic [AW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic [AW-1:0] w_c_re, w_c_im, w_d_re, w_d_im;
    logic [BW-1:0] w_x0_re, w_x0_im, w_x2_re, w_x2_im;
    logic [BW-1:0] w_cs_re, w_cs_im, w_cd_re, w_cd_im;
    logic signed [BW-1:0] w_sel_re;
    logic signed [BW-1:0] w_sel_im;

    // Handshake: a transfer happens on a clk edge only when valid, ready and ce are all
    // high; valid never waits on ready, and a stalled output keeps every field stable.
    assign w_in_ready  = (r_state == COLLECT) & ~rst;
    assign w_out_valid = (r_state == EMIT);
    assign w_in_fire   = in_valid & w_in_ready & ce;
    assign w_out_fire  = w_out_valid & out_ready & ce;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else if (ce) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            COLLECT: if (w_in_fire && r_cnt == 2'd3) w_next = BF1;
            BF1:     w_next = BF2;
            BF2:     w_next = EMIT;
            EMIT:    if (w_out_fire && r_idx == 2'd3) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    bfly2_fwd #(.W(DW)) u_bf1_ac (
        .i_a_re(r_x_re[0]), .i_a_im(r_x_im[0]),
        .i_b_re(r_x_re[2]), .i_b_im(r_x_im[2]),
        .o_sum_re(w_a_re), .o_sum_im(w_a_im),
        .o_dif_re(w_c_re), .o_dif_im(w_c_im)
    );

    bfly2_fwd #(.W(DW)) u_bf1_bd (
        .i_a_re(r_x_re[1]), .i_a_im(r_x_im[1]),
        .i_b_re(r_x_re[3]), .i_b_im(r_x_im[3]),
        .o_sum_re(w_b_re), .o_sum_im(w_b_im),
        .o_dif_re(w_d_re), .o_dif_im(w_d_im)
    );

    bfly2_fwd #(.W(AW)) u_bf2_ab (
        .i_a_re(r_a_re), .i_a_im(r_a_im),
        .i_b_re(r_b_re), .i_b_im(r_b_im),
        .o_sum_re(w_x0_re), .o_sum_im(w_x0_im),
        .o_dif_re(w_x2_re), .o_dif_im(w_x2_im)
    );

    // Feeding d with re/im swapped turns the sum/difference into c-jd and c+jd:
    // X1 = (sum.re, dif.im), X3 = (dif.re, sum.im).
    bfly2_fwd #(.W(AW)) u_bf2_cd (
        .i_a_re(r_c_re), .i_a_im(r_c_im),
        .i_b_re(r_d_im), .i_b_im(r_d_re),
        .o_sum_re(w_cs_re), .o_sum_im(w_cs_im),
        .o_dif_re(w_cd_re), .o_dif_im(w_cd_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_idx <= 2'd0;
            r_a_re <= '0; r_a_im <= '0; r_b_re <= '0; r_b_im <= '0;
            r_c_re <= '0; r_c_im <= '0; r_d_re <= '0; r_d_im <= '0;
            for (int i = 0; i < 4; i++) begin
                r_x_re[i]   <= '0;
                r_x_im[i]   <= '0;
                r_bin_re[i] <= '0;
                r_bin_im[i] <= '0;
            end
        end else if (ce) begin
            if (w_in_fire) begin
                r_x_re[r_cnt] <= in_re;
                r_x_im[r_cnt] <= in_im;
                r_cnt         <= r_cnt + 2'd1;
            end
            if (r_state == BF1) begin
                r_a_re <= w_a_re; r_a_im <= w_a_im;
                r_b_re <= w_b_re; r_b_im <= w_b_im;
                r_c_re <= w_c_re; r_c_im <= w_c_im;
                r_d_re <= w_d_re; r_d_im <= w_d_im;
            end
            if (r_state == BF2) begin
                r_bin_re[0] <= w_x0_re; r_bin_im[0] <= w_x0_im;
                r_bin_re[1] <= w_cs_re; r_bin_im[1] <= w_cd_im;
                r_bin_re[2] <= w_x2_re; r_bin_im[2] <= w_x2_im;
                r_bin_re[3] <= w_cd_re; r_bin_im[3] <= w_cs_im;
            end
            if (w_out_fire) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign w_sel_re = r_bin_re[r_idx];
    assign w_sel_im = r_bin_im[r_idx];

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_re    = w_out_valid ? OW'(w_sel_re) : '0;
    assign out_im    = w_out_valid ? OW'(w_sel_im) : '0;
    assign out_idx   = r_idx;
    assign out_last  = w_out_valid & (r_idx == 2'd3);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fft4_fwd_stream.sv
// Directed bench for fft4_fwd_stream: a direct 4-point DFT model feeds an expected-bin
// queue that is drained as the DUT emits bins.
module tb_fft4_fwd_stream;
    import fft_pkg::*;

    localparam int DW = DW_DEF;
    localparam int OW = ow_of(DW);
    localparam int EW = 2 + 1 + OW + OW;

    logic          clk;
    logic          rst;
    logic          ce;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_re;
    logic [OW-1:0] out_im;
    logic [1:0]    out_idx;
    logic          out_last;
    state_t        dbg_state;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int bins_seen = 0;
    int acc_cyc   = 0;
    int fr_n      = 0;
    int fr_re [4];
    int fr_im [4];
    logic [EW-1:0] exp_q [$];

    fft4_fwd_stream dut (
        .clk(clk), .rst(rst), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack_bin(input int idx, input int re, input int im);
        logic [1:0]    i2;
        logic [OW-1:0] r;
        logic [OW-1:0] m;
        i2 = idx[1:0];
        r  = re[OW-1:0];
        m  = im[OW-1:0];
        return {i2, (idx == 3), r, m};
    endfunction

    // Direct DFT with W = -j: X_k = sum_n x_n * (-j)^(n*k).
    task automatic push_frame();
        int x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
        x0r = fr_re[0]; x0i = fr_im[0]; x1r = fr_re[1]; x1i = fr_im[1];
        x2r = fr_re[2]; x2i = fr_im[2]; x3r = fr_re[3]; x3i = fr_im[3];
        exp_q.push_back(pack_bin(0, x0r + x1r + x2r + x3r, x0i + x1i + x2i + x3i));
        exp_q.push_back(pack_bin(1, x0r + x1i - x2r - x3i, x0i - x1r - x2i + x3r));
        exp_q.push_back(pack_bin(2, x0r - x1r + x2r - x3r, x0i - x1i + x2i - x3i));
        exp_q.push_back(pack_bin(3, x0r - x1i - x2r + x3i, x0i + x1r - x2i - x3r));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && out_valid) chk("in_ready_during_emit", in_ready, 0);
        if (!rst && out_valid && out_ready && ce) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_bin: got idx %0d re %0d im %0d, expected no bin",
                       out_idx, $signed(out_re), $signed(out_im));
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bin_idx",  out_idx, e[EW-1 -: 2]);
                chk("bin_last", out_last, e[2*OW]);
                chk("bin_re",   $signed(out_re), $signed(e[2*OW-1 -: OW]));
                chk("bin_im",   $signed(out_im), $signed(e[OW-1:0]));
            end
            bins_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic send(input int re, input int im);
        bit got;
        int t;
        got = 0;
        t = 0;
        in_valid = 1'b1;
        in_re = re[DW-1:0];
        in_im = im[DW-1:0];
        while (!got && t < 200) begin
            @(negedge clk);
            if (in_ready && ce && !rst) begin
                got = 1;
                acc_cyc = cyc;
            end else begin
                @(posedge clk); #2;
            end
            t++;
        end
        chk("send_accepted", got, 1);
        if (got) begin
            fr_re[fr_n] = re;
            fr_im[fr_n] = im;
            fr_n++;
            if (fr_n == 4) begin
                push_frame();
                fr_n = 0;
            end
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int r0, i0, r1, i1, r2, i2, r3, i3);
        send(r0, i0); send(r1, i1); send(r2, i2); send(r3, i3);
    endtask

    task automatic send_random_frame();
        for (int k = 0; k < 4; k++)
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        chk("rst_in_ready_low", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        exp_q.delete();
        fr_n = 0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_state", dbg_state, COLLECT);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_out_re", $signed(out_re), 0);
        chk("post_rst_out_im", $signed(out_im), 0);
        chk("post_rst_out_idx", out_idx, 0);
        chk("post_rst_out_last", out_last, 0);
        @(posedge clk); #2;
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s_re, s_im, s_idx, base;
        int start [3];
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_re = '0; in_im = '0;
        do_reset();

        // Impulse, plus the accept-to-valid latency
        send_frame(1, 0, 0, 0, 0, 0, 0, 0);
        base = acc_cyc;
        wait_valid("impulse_valid");
        chk("latency_cycles", cyc - base, 3);
        drain();

        // Bin-1 tone
        send_frame(1, 0, 0, 1, -1, 0, 0, -1);
        drain();

        // Full-scale extremes
        send_frame(-128, -128, -128, -128, -128, -128, -128, -128);
        send_frame(127, -128, 127, -128, 127, -128, 127, -128);
        drain();

        // Backpressure: stall on bin 1 for 5 cycles
        out_ready = 1'b0;
        send_random_frame();
        wait_valid("bp_valid");
        @(posedge clk); #2; out_ready = 1'b1;
        @(posedge clk); #2; out_ready = 1'b0;
        @(negedge clk);
        s_re = $signed(out_re); s_im = $signed(out_im); s_idx = out_idx;
        chk("bp_at_idx1", s_idx, 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_idx_stable", out_idx, s_idx);
            chk("bp_re_stable", $signed(out_re), s_re);
            chk("bp_im_stable", $signed(out_im), s_im);
            chk("bp_valid_held", out_valid, 1);
        end
        @(posedge clk); #2; out_ready = 1'b1;
        drain();

        // ce low mid-collect with a junk sample offered, then ce low during emit
        send(1, 0); send(0, 1);
        in_valid = 1'b1; in_re = 8'd99; in_im = 8'd157; ce = 1'b0;
        idle(3);
        @(negedge clk);
        chk("ce_low_state", dbg_state, COLLECT);
        @(posedge clk); #2;
        in_valid = 1'b0; ce = 1'b1;
        send(-1, 0); send(0, -1);
        wait_valid("ce_valid");
        @(posedge clk); #2; ce = 1'b0;
        idle(3);
        @(negedge clk);
        chk("ce_low_emit_idx", out_idx, 1);
        @(posedge clk); #2; ce = 1'b1;
        drain();

        // Reset after two accepted samples: the partial frame is dropped
        send(50, 50); send(-50, 20);
        do_reset();
        send_frame(3, -4, 10, 7, -9, 2, 5, -6);
        drain();

        // Reset during emit at bin 2: bins 2 and 3 never appear
        out_ready = 1'b0;
        send_random_frame();
        wait_valid("rst_emit_valid");
        @(posedge clk); #2; out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_emit_at_idx2", out_idx, 2);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2;
        @(negedge clk);
        chk("rst_emit_valid_low", out_valid, 0);
        chk("rst_emit_idx_zero", out_idx, 0);
        exp_q.delete();
        fr_n = 0;
        @(posedge clk); #2; rst = 1'b0; out_ready = 1'b1;
        base = bins_seen;
        idle(15);
        chk("rst_emit_no_more_bins", bins_seen - base, 0);

        // Back-to-back frames with a source that never drops valid
        base = bins_seen;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
                if (k == 0) start[f] = acc_cyc;
            end
        end
        drain();
        chk("b2b_period_1", start[1] - start[0], 10);
        chk("b2b_period_2", start[2] - start[1], 10);
        chk("b2b_bin_count", bins_seen - base, 12);

        // Final report
        idle(2);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
